dense_seq: RTL and testbench
============================

# dense_seq

Layer sequencer for the shared dense (fully-connected) engine. It runs a fixed, multi-layer classifier head one layer at a time on the single dense datapath. For each layer it:
- loads that layer's sizes, weight base address and activation mode,
- launches the engine and waits for it to finish,
- swaps the ping-pong activation buffers before the next layer.

It sits between the CNN front-end's hand-off (`start`) and the dense engine's controller, and reports completion or a launch fault upstream.

## Interface
- `NUM_LAYERS`, default 2: dense layers per inference, at least 1.
- `CNT_W`, default 10: width of the size fields.
- `ADDR_W`, default 15: width of the weight-memory base address.
- `ACK_TO`, default 4: cycles allowed between `engStart` and `engBusy` rising.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; a new input vector is in buffer 0.
- `clrErr` in 1: clears the sticky error and returns to IDLE.
- `engBusy` in 1: dense engine busy.
- `engStart` out 1: one-cycle launch pulse to the engine.
- `engInSize` out CNT_W: input length of the current layer.
- `engOutSize` out CNT_W: output length of the current layer.
- `engWBase` out ADDR_W: weight/bias base address of the current layer.
- `engRelu` out 1: apply ReLU on write-back.
- `engBufSel` out 1: 0 means read buffer A / write buffer B; 1 means the reverse.
- `layerIdx` out clog2(NUM_LAYERS), minimum 1: current layer.
- `busy` out 1: high in every state except IDLE and ERR.
- `done` out 1: one-cycle pulse when the last layer completes.
- `err` out 1: sticky launch-timeout flag.

## Operation
- States: IDLE, CFG, LAUNCH, WAIT_ACK, RUN, SWAP, DONE, ERR.
- IDLE
  - `start` → CFG. `layerIdx`=0 and `engBufSel`=0 are set on this transition.
  - `start` is ignored in every other state. It is not queued.
- CFG
  - Registers `engInSize`, `engOutSize`, `engWBase` and `engRelu` from the package table at `layerIdx`.
  - → LAUNCH unconditionally.
- LAUNCH
  - `engStart`=1 for exactly this cycle.
  - Clears the timeout counter.
  - → WAIT_ACK.
- WAIT_ACK
  - `engBusy`=1 → RUN.
  - Otherwise the counter increments. When it reaches ACK_TO → ERR.
- RUN
  - `engBusy`=0 → SWAP. Config outputs are held stable throughout.
- SWAP
  - Toggles `engBufSel`.
  - If `layerIdx`==NUM_LAYERS-1 → DONE.
  - Otherwise `layerIdx`+1 → CFG.
- DONE
  - `done`=1 for one cycle → IDLE.
  - Final results are in the buffer last written, i.e. the buffer selected by (`engBufSel` after the toggle)==0 ? A : B.
- ERR
  - `err`=1 and `busy`=0. Stays until `clrErr`=1 → IDLE.
  - Entering ERR asserts no `engStart`.
- `clrErr` outside ERR has no effect.
- Reset value of every output is 0. State resets to IDLE; `layerIdx` and the counter reset to 0.
- Reset mid-RUN abandons the layer. The engine is reset by the same `rst`.
- `layerIdx` never exceeds NUM_LAYERS-1; it does not wrap during a run.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- `start` sampled at edge 0 → CFG in cycle 1 → `engStart` high in cycle 2.
- Config outputs are valid from cycle 2 and do not change while `engStart` or `engBusy` is high.
- An engine that raises `engBusy` the cycle after `engStart` enters RUN one cycle later.
- Per-layer overhead outside RUN: CFG + LAUNCH + WAIT_ACK(≥1) + SWAP = 4 cycles minimum. DONE adds 1.
- Timeout: `engBusy` still 0 at the ACK_TO-th WAIT_ACK cycle → ERR on the next edge.
- `engBusy` dropping in the same cycle it is first seen high is treated as a normal RUN entry. SWAP follows on the next low.
- `start` in the DONE cycle is ignored. `start` in the following IDLE cycle is accepted.

## Structure
- Shared package `dense_pkg` holds:
  - state encoding constants,
  - `NUM_LAYERS`,
  - per-layer constant arrays `LAYER_IN`, `LAYER_OUT`, `LAYER_WBASE`, `LAYER_RELU`.
- Package defaults:
  - Layer 0: in 200, out 64, base 0, relu 1.
  - Layer 1: in 64, out 10, base 12864, relu 0. 12864 = 200·64 weights + 64 biases.
- One sub-module, `dense_seq_timer`: loadable up-counter with a terminal flag for the ACK timeout. It is cleared in LAUNCH.
- The FSM and the config registers stay in `dense_seq`.

## Test plan
- Two-layer run, engine busy 1 cycle after launch for 20 cycles:
  - two `engStart` pulses, with the first at cycle 2;
  - config 200/64/0/1, then 64/10/12864/0;
  - `engBufSel` 0→1→0;
  - a single `done` pulse; `busy` low afterwards.
- `start` pulsed during RUN of layer 0 → no extra `engStart`, and exactly one `done`.
- `engBusy` held 0 after launch → `err`=1 and `busy`=0 exactly ACK_TO+1 cycles after `engStart`; `clrErr` → IDLE, then a fresh `start` runs cleanly.
- `rst` asserted mid-RUN of layer 1 → all outputs 0 asynchronously; the next `start` begins at layer 0 with `engBufSel`=0.
- NUM_LAYERS=1 build → one launch; SWAP goes straight to DONE; `layerIdx` stays 0.
- `start` in the DONE cycle, then again 1 cycle later → the first is ignored, the second launches at +2 cycles.

Source files
------------

// File: rtl/dense_seq_pkg.sv
// Shared definitions for the dense-layer sequencer: FSM states and the fixed layer table.
// Layer 1 weights start after layer 0's 200x64 weights plus 64 biases.
package dense_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_RUN,
        ST_SWAP,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int NUM_LAYERS = 2;

    localparam int LAYER_IN    [NUM_LAYERS] = '{200, 64};
    localparam int LAYER_OUT   [NUM_LAYERS] = '{64, 10};
    localparam int LAYER_WBASE [NUM_LAYERS] = '{0, 12864};
    localparam bit LAYER_RELU  [NUM_LAYERS] = '{1'b1, 1'b0};

endpackage

// File: rtl/dense_seq_if.sv
// Launch/config bundle between the layer sequencer (master) and the dense engine (slave).
// engBusy is the engine's only return signal; everything else is held by the sequencer.
interface dense_seq_if #(
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 15
);
    logic              engStart;
    logic              engBusy;
    logic [CNT_W-1:0]  engInSize;
    logic [CNT_W-1:0]  engOutSize;
    logic [ADDR_W-1:0] engWBase;
    logic              engRelu;
    logic              engBufSel;

    modport master (
        output engStart, engInSize, engOutSize, engWBase, engRelu, engBufSel,
        input  engBusy
    );

    modport slave (
        input  engStart, engInSize, engOutSize, engWBase, engRelu, engBufSel,
        output engBusy
    );
endinterface

// File: rtl/dense_seq_timer.sv
// Loadable up-counter for the engine acknowledge timeout; term flags the LIMIT-th counted cycle.
// One-cycle latency from ld/inc to cnt; saturates at LIMIT, no backpressure.
module dense_seq_timer #(
    parameter  int LIMIT = 4,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    output logic         term
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle's increment is the one that reaches LIMIT.
    assign term = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/dense_seq.sv
// Runs the classifier head one dense layer at a time: configure, launch, wait, swap buffers.
// start->engStart is 2 cycles; 4 cycles of overhead per layer plus 1 for DONE; start ignored while busy.
module dense_seq #(
    parameter  int NUM_LAYERS = dense_pkg::NUM_LAYERS,
    parameter  int CNT_W      = 10,
    parameter  int ADDR_W     = 15,
    parameter  int ACK_TO     = 4,
    localparam int LIDX_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              clrErr,
    dense_seq_if.master       eng,
    output logic [LIDX_W-1:0] layerIdx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import dense_pkg::*;

    state_e             state_q, state_d;
    logic [LIDX_W-1:0]  layer_idx_q, layer_idx_d;
    logic               buf_sel_q, buf_sel_d;
    logic [CNT_W-1:0]   in_size_q, in_size_d;
    logic [CNT_W-1:0]   out_size_q, out_size_d;
    logic [ADDR_W-1:0]  wbase_q, wbase_d;
    logic               relu_q, relu_d;
    logic               tmr_ld;
    logic               tmr_inc;
    logic               tmr_term;

    dense_seq_timer #(.LIMIT(ACK_TO)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .ld     (tmr_ld),
        .ld_val ('0),
        .inc    (tmr_inc),
        .term   (tmr_term)
    );

    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        buf_sel_d   = buf_sel_q;
        in_size_d   = in_size_q;
        out_size_d  = out_size_q;
        wbase_d     = wbase_q;
        relu_d      = relu_q;
        tmr_ld      = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    layer_idx_d = '0;
                    buf_sel_d   = 1'b0;
                    state_d     = ST_CFG;
                end
            end
            ST_CFG: begin
                in_size_d  = CNT_W'(LAYER_IN[layer_idx_q]);
                out_size_d = CNT_W'(LAYER_OUT[layer_idx_q]);
                wbase_d    = ADDR_W'(LAYER_WBASE[layer_idx_q]);
                relu_d     = LAYER_RELU[layer_idx_q];
                state_d    = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                tmr_ld  = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // An acknowledge on the last allowed cycle still wins over the timeout.
                if (eng.engBusy) begin
                    state_d = ST_RUN;
                end else begin
                    tmr_inc = 1'b1;
                    if (tmr_term) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RUN: begin
                if (!eng.engBusy) begin
                    state_d = ST_SWAP;
                end
            end
            ST_SWAP: begin
                buf_sel_d = ~buf_sel_q;
                if (layer_idx_q == LIDX_W'(NUM_LAYERS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    layer_idx_d = layer_idx_q + 1'b1;
                    state_d     = ST_CFG;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (clrErr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            layer_idx_q <= '0;
            buf_sel_q   <= 1'b0;
            in_size_q   <= '0;
            out_size_q  <= '0;
            wbase_q     <= '0;
            relu_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            buf_sel_q   <= buf_sel_d;
            in_size_q   <= in_size_d;
            out_size_q  <= out_size_d;
            wbase_q     <= wbase_d;
            relu_q      <= relu_d;
        end
    end

    assign eng.engStart   = (state_q == ST_LAUNCH);
    assign eng.engInSize  = in_size_q;
    assign eng.engOutSize = out_size_q;
    assign eng.engWBase   = wbase_q;
    assign eng.engRelu    = relu_q;
    assign eng.engBufSel  = buf_sel_q;
    assign layerIdx       = layer_idx_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign done           = (state_q == ST_DONE);
    assign err            = (state_q == ST_ERR);

endmodule

// File: tb/tb_dense_seq.sv
// Bench for dense_seq: a behavioural engine plus an arithmetic timeline model of each inference.
`timescale 1ns/1ps
module tb_dense_seq;
    localparam int CNT_W  = 10;
    localparam int ADDR_W = 15;
    localparam int ACK_TO = 4;
    localparam int NL     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, clr_err = 1'b0, start1 = 1'b0, clr1 = 1'b0;
    logic [0:0] layer_idx, layer_idx1;
    logic       busy, done, err, busy1, done1, err1;

    dense_seq_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) eng_if ();
    dense_seq_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) eng1_if ();

    dense_seq #(.NUM_LAYERS(NL), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .ACK_TO(ACK_TO)) dut (
        .clk(clk), .rst(rst), .start(start), .clrErr(clr_err), .eng(eng_if),
        .layerIdx(layer_idx), .busy(busy), .done(done), .err(err)
    );

    dense_seq #(.NUM_LAYERS(1), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .ACK_TO(ACK_TO)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .clrErr(clr1), .eng(eng1_if),
        .layerIdx(layer_idx1), .busy(busy1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference layer table, taken straight from the classifier definition.
    int ref_in  [NL] = '{200, 64};
    int ref_out [NL] = '{64, 10};
    int ref_wb  [NL] = '{0, 12864};
    bit ref_relu[NL] = '{1'b1, 1'b0};

    // Engine behaviour per layer: busy rises eng_a cycles after engStart, stays eng_d cycles.
    int eng_a[NL];
    int eng_d[NL];
    int eng_n, eng_rise, eng_fall;

    int exp_launch[NL];
    int exp_swap[NL];
    int exp_done, exp_err, n_exp;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (eng_if.engStart === 1'b1 && eng_n < NL) begin
            eng_rise = cyc + eng_a[eng_n];
            eng_fall = eng_rise + eng_d[eng_n];
            eng_n++;
        end
        eng_if.engBusy = (cyc >= eng_rise) && (cyc < eng_fall);
    endtask

    // Timeline of one inference whose start is sampled at the end of cycle s.
    function automatic void predict(input int s);
        int l;
        l = s + 2;
        exp_done = -1;
        exp_err  = -1;
        n_exp    = 0;
        for (int k = 0; k < NL; k++) begin
            exp_launch[k] = -1;
            exp_swap[k]   = -1;
        end
        for (int k = 0; k < NL; k++) begin
            exp_launch[k] = l;
            n_exp++;
            if (eng_a[k] > ACK_TO) begin
                exp_err = l + ACK_TO + 1;
                return;
            end
            exp_swap[k] = l + eng_a[k] + eng_d[k] + 1;
            l = exp_swap[k] + 2;
        end
        exp_done = exp_swap[NL-1] + 1;
    endfunction

    task automatic run_check(input string name, input int abort_off, input int noise_off, input bit dbl);
        int s, last, k, hi;
        logic [3:0]  got4, want4;
        logic [37:0] got, want;
        s = cyc;
        eng_n = 0; eng_rise = -1; eng_fall = -1;
        predict(s);
        last = (exp_err >= 0) ? exp_err + 1 : exp_done + 1;
        hi   = (exp_err >= 0) ? exp_err - 1 : exp_done;
        while (cyc < last && (abort_off < 0 || cyc < s + abort_off)) begin
            start   = (cyc == s) || (noise_off > 0 && cyc == s + noise_off) || (dbl && cyc == exp_done);
            clr_err = (noise_off > 0 && cyc == s + noise_off);
            tick();
            want4 = 4'b0;
            k = -1;
            for (int j = 0; j < n_exp; j++) begin
                if (cyc == exp_launch[j]) want4[3] = 1'b1;
                if (cyc >= exp_launch[j] && cyc <= ((exp_swap[j] >= 0) ? exp_swap[j] : last)) k = j;
            end
            want4[2] = (cyc == exp_done);
            want4[1] = (cyc > s) && (cyc <= hi);
            want4[0] = (exp_err >= 0) && (cyc >= exp_err);
            got4 = {eng_if.engStart, done, busy, err};
            n_checks++;
            if (got4 !== want4) begin
                n_fail++;
                $display("FAIL %s ctrl cyc=%0d start/done/busy/err got=%b want=%b", name, cyc - s, got4, want4);
            end
            if (k >= 0) begin
                got  = {eng_if.engInSize, eng_if.engOutSize, eng_if.engWBase, eng_if.engRelu,
                        layer_idx, eng_if.engBufSel};
                want = {CNT_W'(ref_in[k]), CNT_W'(ref_out[k]), ADDR_W'(ref_wb[k]), ref_relu[k],
                        1'(k), 1'(k % 2)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s cfg cyc=%0d layer=%0d got=%h want=%h", name, cyc - s, k, got, want);
                end
            end
            if (cyc == exp_done) begin
                n_checks++;
                if (eng_if.engBufSel !== 1'(NL % 2)) begin
                    n_fail++;
                    $display("FAIL %s final_bufsel got=%b want=%b", name, eng_if.engBufSel, 1'(NL % 2));
                end
            end
        end
        start   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] got;
        eng_if.engBusy  = 1'b0;
        eng1_if.engBusy = 1'b0;
        eng_n = 0; eng_rise = -1; eng_fall = -1;
        tick();
        tick();
        got = {eng_if.engStart, eng_if.engInSize, eng_if.engOutSize, eng_if.engWBase, eng_if.engRelu,
               eng_if.engBufSel, layer_idx, busy, done, err};
        n_checks++;
        if (got !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        n_checks++;
        if ({eng1_if.engStart, layer_idx1, busy1, done1, err1} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_1layer got=%b want=0", {eng1_if.engStart, layer_idx1, busy1, done1, err1});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_two_layer();
        eng_a = '{1, 1};
        eng_d = '{20, 20};
        run_check("two_layer", -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < NL; k++) begin
                eng_a[k] = $urandom_range(ACK_TO, 1);
                eng_d[k] = $urandom_range(25, 1);
            end
            run_check("random", -1, -1, 1'b0);
            repeat ($urandom_range(3, 0)) tick();
        end
    endtask

    task automatic test_start_during_run();
        eng_a = '{1, 1};
        eng_d = '{20, 20};
        run_check("start_in_run", -1, 7, 1'b0);
    endtask

    task automatic test_timeout();
        eng_a = '{100, 1};
        eng_d = '{5, 5};
        run_check("timeout", -1, -1, 1'b0);
        repeat (3) begin
            tick();
            n_checks++;
            if ({err, busy} !== 2'b10) begin
                n_fail++;
                $display("FAIL timeout_sticky err/busy got=%b want=10", {err, busy});
            end
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++;
        if ({err, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_clear err/busy got=%b want=00", {err, busy});
        end
        eng_a = '{2, 3};
        eng_d = '{4, 6};
        run_check("after_clear", -1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        logic [39:0] got;
        eng_a = '{1, 2};
        eng_d = '{6, 10};
        run_check("pre_reset", 17, -1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        got = {eng_if.engStart, eng_if.engInSize, eng_if.engOutSize, eng_if.engWBase, eng_if.engRelu,
               eng_if.engBufSel, layer_idx, busy, done, err};
        n_checks++;
        if (got !== 40'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=0", got);
        end
        tick();
        eng_n = NL; eng_rise = -1; eng_fall = -1;
        eng_if.engBusy = 1'b0;
        rst = 1'b1;
        tick();
        eng_a = '{1, 1};
        eng_d = '{3, 3};
        run_check("post_reset", -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        eng_a = '{1, 1};
        eng_d = '{4, 4};
        run_check("done_start", -1, -1, 1'b1);
        eng_a = '{2, 1};
        eng_d = '{5, 3};
        run_check("idle_start", -1, -1, 1'b0);
    endtask

    task automatic test_single_layer();
        int s, launches, l, dn, d;
        logic [37:0] got;
        s = cyc; launches = 0; l = -1; dn = -1; d = 7;
        start1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            start1 = 1'b0;
            if (eng1_if.engStart === 1'b1) begin
                launches++;
                l = cyc;
                got = {eng1_if.engInSize, eng1_if.engOutSize, eng1_if.engWBase, eng1_if.engRelu,
                       layer_idx1, eng1_if.engBufSel};
                n_checks++;
                if (got !== {10'd200, 10'd64, 15'd0, 1'b1, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL single_cfg got=%h", got);
                end
            end
            eng1_if.engBusy = (l >= 0) && (cyc >= l + 1) && (cyc < l + 1 + d);
            if (done1 === 1'b1) begin
                dn = cyc;
                n_checks++;
                if (eng1_if.engBufSel !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_bufsel got=%b want=1", eng1_if.engBufSel);
                end
            end
            n_checks++;
            if (layer_idx1 !== 1'b0) begin
                n_fail++;
                $display("FAIL single_layeridx cyc=%0d got=%b want=0", cyc - s, layer_idx1);
            end
        end
        n_checks++;
        if (launches !== 1 || l !== s + 2 || dn !== s + 2 + d + 3) begin
            n_fail++;
            $display("FAIL single_timeline launches=%0d launch=%0d done=%0d want 1/%0d/%0d",
                     launches, l - s, dn - s, 2, 2 + d + 3);
        end
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_after got=%b want=0", busy1);
        end
    endtask

    initial begin
        test_reset();
        test_two_layer();
        test_start_during_run();
        test_random();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        test_single_layer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
